// File: rtl/swerv_types.sv
// Shared SweRV execution-unit types, including the packet sent to the multiplier.
package swerv_types;

  localparam int MUL_LAT = 3;

  typedef struct packed {
    logic valid;
    logic rs1_sign;
    logic rs2_sign;
    logic low;
    logic load_mul_rs1_bypass_e1;
    logic load_mul_rs2_bypass_e1;
  } mul_pkt_t;

endpackage

// File: rtl/exu_mul_arb.sv
// Two-requester round-robin front end for a shared 3-cycle multiplier.
// A shadow pipe tracks requester and tag so that results route back to their owner.
module exu_mul_arb
  import swerv_types::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_rs1_sign,
  input  logic             req0_rs2_sign,
  input  logic             req0_low,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_rs1_sign,
  input  logic             req1_rs2_sign,
  input  logic             req1_low,
  input  logic [TAG_W-1:0] req1_tag,

  output mul_pkt_t         mul_mp,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_out,

  output logic             res_valid,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,

  output logic [1:0]       outst0,
  output logic [1:0]       outst1,
  output logic             busy
);

  logic             grant_ok;
  logic             favour;
  logic             acc0;
  logic             acc1;
  logic             accept;
  logic [TAG_W-1:0] win_tag;

  logic             v_sh   [1:MUL_LAT];
  logic             src_sh [1:MUL_LAT];
  logic [TAG_W-1:0] tag_sh [1:MUL_LAT];

  logic [1:0]       inc;
  logic [1:0]       dec;
  logic [1:0]       cnt [0:1];

  // Each ready means "this requester would win if it were valid".
  assign grant_ok   = ~freeze & ~flush;
  assign req0_ready = grant_ok & (~favour | ~req1_valid);
  assign req1_ready = grant_ok & ( favour | ~req0_valid);

  assign acc0    = req0_valid & req0_ready;
  assign acc1    = req1_valid & req1_ready;
  assign accept  = acc0 | acc1;
  assign win_tag = acc1 ? req1_tag : req0_tag;

  assign mul_mp.valid                  = accept;
  assign mul_mp.rs1_sign               = acc1 ? req1_rs1_sign : req0_rs1_sign;
  assign mul_mp.rs2_sign               = acc1 ? req1_rs2_sign : req0_rs2_sign;
  assign mul_mp.low                    = acc1 ? req1_low      : req0_low;
  assign mul_mp.load_mul_rs1_bypass_e1 = 1'b0;
  assign mul_mp.load_mul_rs2_bypass_e1 = 1'b0;
  assign mul_a = acc1 ? req1_a : req0_a;
  assign mul_b = acc1 ? req1_b : req0_b;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      favour <= 1'b0;
    end else if (accept) begin
      favour <= acc0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 1; i <= MUL_LAT; i++) begin
        v_sh[i]   <= 1'b0;
        src_sh[i] <= 1'b0;
        tag_sh[i] <= '0;
      end
    end else begin
      if (!freeze) begin
        v_sh[1]   <= accept;
        src_sh[1] <= acc1;
        tag_sh[1] <= win_tag;
        for (int i = 2; i <= MUL_LAT; i++) begin
          v_sh[i]   <= v_sh[i-1];
          src_sh[i] <= src_sh[i-1];
          tag_sh[i] <= tag_sh[i-1];
        end
      end
      // Flush kills every stage even while frozen.
      if (flush) begin
        for (int i = 1; i <= MUL_LAT; i++) begin
          v_sh[i] <= 1'b0;
        end
      end
    end
  end

  assign res_valid = v_sh[MUL_LAT] & ~freeze & ~flush;
  assign res_src   = src_sh[MUL_LAT];
  assign res_tag   = tag_sh[MUL_LAT];
  assign res_data  = mul_out;
  assign busy      = v_sh[1] | v_sh[2] | v_sh[3];

  assign inc[0] = acc0;
  assign inc[1] = acc1;
  assign dec[0] = res_valid & ~res_src;
  assign dec[1] = res_valid &  res_src;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt[0] <= 2'd0;
      cnt[1] <= 2'd0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (flush) begin
          cnt[n] <= 2'd0;
        end else if (inc[n] && !dec[n] && cnt[n] != 2'd3) begin
          cnt[n] <= cnt[n] + 2'd1;
        end else if (dec[n] && !inc[n] && cnt[n] != 2'd0) begin
          cnt[n] <= cnt[n] - 2'd1;
        end
      end
    end
  end

  assign outst0 = cnt[0];
  assign outst1 = cnt[1];

endmodule

// File: doc/exu_mul_arb.md
EXU_MUL_ARB -- requirements
Module: exu_mul_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the requester result tag.
REQ-002 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_l  in  1: reset, asynchronous and active-low.
REQ-004 SHALL have port freeze  in  1: pipeline freeze; no accept, no shadow advance.
REQ-005 SHALL have port flush  in  1: kill all in-flight operations.
REQ-006 SHALL have ports reqN_valid  in  1 (N=0,1): requester N has an operation.
REQ-007 SHALL have ports reqN_ready  out  1: requester N accepted this cycle when valid and ready.
REQ-008 SHALL have ports reqN_a, reqN_b  in  32: operands.
REQ-009 SHALL have ports reqN_rs1_sign, reqN_rs2_sign, reqN_low  in  1: operation control.
REQ-010 SHALL have ports reqN_tag  in  TAG_W: returned unchanged with the result.
REQ-011 SHALL have port mul_mp  out  mul_pkt_t: packet to the multiplier.
REQ-012 SHALL have ports mul_a, mul_b  out  32: operands to the multiplier.
REQ-013 SHALL have port mul_out  in  32: multiplier result, 3 cycles after issue.
REQ-014 SHALL have ports res_valid, res_src  out  1: result strobe and originating requester.
REQ-015 SHALL have ports res_tag  out  TAG_W and res_data  out  32: result tag and data.
REQ-016 SHALL have ports outstN  out  2: count of in-flight operations from requester N.
REQ-017 SHALL have port busy  out  1: any shadow stage valid.

Function
REQ-018 SHALL grant at most one requester per cycle; grant only if ~freeze & ~flush.
REQ-019 SHALL arbitrate round-robin: a favour pointer selects the winner when both are valid; after an accept it points to the other requester; it holds when there is no accept.
REQ-020 SHALL drive reqN_ready combinationally, independent of reqN_valid; it is asserted only for the requester that would win.
REQ-021 SHALL set mul_mp.valid = accept and pass the winner's a/b/sign/low fields; load_mul_rs1/rs2_bypass_e1 = 0.
REQ-022 SHALL keep a 3-stage shadow pipe {valid, src, tag} (e1..e3) that advances only when ~freeze; a frozen stage holds.
REQ-023 SHALL drive res_valid = v_e3 & ~freeze & ~flush; res_data = mul_out; res_src/res_tag from e3.
REQ-024 Latency: an accept at cycle T gives res_valid at T+3 without freeze, plus one cycle per frozen cycle; throughput 1/cycle.
REQ-025 SHALL clear all shadow valid bits at the next edge on flush; no accept occurs in a flush cycle.
REQ-026 SHALL increment outstN on accept from N and decrement it on res_valid with src N; simultaneous increment and decrement leaves it unchanged; flush zeroes it; max 3, no wrap.
REQ-027 SHALL assert busy = v_e1 | v_e2 | v_e3.

Reset
REQ-028 SHALL reset, asynchronously: shadow valids 0, favour pointer to requester 0, outst0/outst1 0; therefore res_valid, busy, mul_mp.valid = 0.
REQ-029 On reset assertion mid-operation, SHALL discard in-flight results; no res_valid after release.

Structure
REQ-030 SHALL take mul_pkt_t from swerv_types and add MUL_LAT = 3 there; no new typedef.
REQ-031 SHALL have no sub-module other than codebase flop primitives; the multiplier is instantiated by the parent.

Verification
REQ-032 Single op: req0 a=7, b=6, low=1, tag=3 at T0 -> res_valid T3, data 42, src 0, tag 3.
REQ-033 Contention: both valid for 4 cycles -> grants 0,1,0,1; tags return in the same order at T3..T6.
REQ-034 Freeze: accept at T0, freeze T1-T2 -> no ready T1-T2, res_valid at T5 only, once.
REQ-035 Flush: three back-to-back accepts, flush at T2 -> no res_valid, outst0 = 0 and busy = 0 at T3.
REQ-036 Signed high: rs1_sign=rs2_sign=1, a=0xFFFFFFFF, b=2, low=0 -> res_data 0xFFFFFFFF.
REQ-037 Reset: assert rst_l low with 2 ops in flight -> res_valid stays 0, outst 0, pointer 0.
